i2c_slave_opencores: RTL and testbench
======================================

Name: i2c_slave_opencores

Overview:
I2C target (slave) that answers one fixed 7-bit address. It is the bus-side counterpart of the team's I2C master core.
- Exposes a byte-wide register-access strobe interface to user logic, with an auto-incrementing register pointer.
- Pad signals are split in/out/enable like the master core, so the top level wires both onto the same open-drain pins.
- Standard/fast mode; wb_clk_i must be ≥ 20× the SCL rate.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C address this target ACKs
REG_ADDR_W, 8, register pointer width; pointer wraps modulo 2^REG_ADDR_W
SYNC_STAGES, 2, synchronizer flops on scl_pad_in/sda_pad_in (min 2)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, synchronous, active-high
scl_pad_in  in  1  SCL pin state
sda_pad_in  in  1  SDA pin state
scl_pad_out  out  1  constant 0 (open-drain)
scl_pad_en  out  1  active-low drive enable; 1 = released
sda_pad_out  out  1  constant 0 (open-drain)
sda_pad_en  out  1  active-low drive enable; 0 = pull SDA low
reg_addr_o  out  REG_ADDR_W  current register pointer
reg_wdata_o  out  8  write data, valid with reg_we_o
reg_we_o  out  1  one-cycle write strobe
reg_rd_o  out  1  one-cycle read strobe
reg_rdata_i  in  8  read data, sampled the cycle after reg_rd_o
busy_o  out  1  high from address match until STOP/NACK/mismatch

Behaviour:
- Reset values:
  - sda_pad_en=1, scl_pad_en=1, sda_pad_out=0, scl_pad_out=0.
  - reg_addr_o=0, reg_wdata_o=0, strobes=0, busy_o=0.
  - FSM=IDLE, synchronizers preset to 1.
- Bus conditioning:
  - Inputs pass through SYNC_STAGES flops; edges are detected on the synced values.
  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Bit timing:
  - Receive bits are sampled on the SCL rising edge, MSB first.
  - SDA drive changes only on SCL falling-edge detection.
  - Pad latency: 1 clk after the detect cycle.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE→ADDR on START.
- ADDR: shift 8 bits.
  - Match SLAVE_ADDR: ACK by driving SDA low from the falling edge after bit 8 to the next falling edge; enter ADDR_ACK.
  - Mismatch: release SDA and go IDLE, ignoring the bus until the next START.
- R/W=0 path:
  - ADDR_ACK→PTR. First byte loads reg_addr_o (low REG_ADDR_W bits), ACK, →PTR_ACK→WDATA.
  - Each WDATA byte: reg_wdata_o=byte and reg_we_o pulses 1 clk at the ACK falling edge; ACK.
  - reg_addr_o increments the cycle after reg_we_o.
- R/W=1 path:
  - reg_rd_o pulses at the start of the address ACK; reg_rdata_i is latched next clk.
  - MSB is driven at the falling edge ending ACK; →RDATA.
  - After 8 bits: release SDA, sample the master ACK on the rising edge.
    - ACK (SDA=0): reg_addr_o++, reg_rd_o pulses immediately, next byte.
    - NACK: →IDLE, busy_o=0.
- Pointer wraps from 2^REG_ADDR_W−1 to 0.
- Repeated START in any state → ADDR; the pointer is retained, so write-ptr then Sr-read works.
- STOP in any state → IDLE, SDA released the same cycle as detection, busy_o=0. A partial byte is discarded (no strobe).
- wb_rst_i asserted mid-transfer: all outputs return to reset values next clk; SDA/SCL are released.
- reg_we_o and reg_rd_o are never high in the same cycle.

Optional Feature:
Macro: I2C_SLAVE_CLK_STRETCH_EN.
- Defined:
  - Extra input reg_rdy_i (1 bit).
  - After every reg_we_o or reg_rd_o, SCL is held low (scl_pad_en=0) from the next SCL falling edge until reg_rdy_i=1 is sampled. SCL is released 1 clk later.
  - For reads, reg_rdata_i is captured in the cycle reg_rdy_i is sampled high, not the cycle after reg_rd_o.
- Undefined:
  - No reg_rdy_i port; scl_pad_en tied 1.
  - Read data must be valid the cycle after reg_rd_o.

Decomposition:
- Package i2c_slave_pkg: FSM state enum, ACK/NACK constants, default SLAVE_ADDR.
- Sub-module i2c_slave_bus_cond: synchronizers, SCL rise/fall detect, START/STOP detect; outputs one-cycle pulses.

Test Plan:
- Write 0xA0 (addr 0x50, W), ptr 0x10, data 0x11, 0x22, STOP → ACK ×4; reg_we_o at ptr 0x10=0x11 then 0x11=0x22; busy_o falls at STOP.
- Write ptr 0x20, Sr, 0xA1, master ACK,NACK with reg_rdata_i = ptr+1 → bytes 0x21, 0x22 on SDA; reg_rd_o ×2 (no third); FSM IDLE after NACK.
- Address 0x51 → SDA never driven, no strobes, busy_o stays 0.
- Pointer 0xFF write of 2 bytes → writes at 0xFF then 0x00.
- STOP after 4 data bits → no reg_we_o, SDA released, next START accepted; wb_rst_i mid-ACK → sda_pad_en=1 next clk.
- [CLK_STRETCH_EN] reg_rdy_i delayed 50 clk → SCL held low ≥50 clk after falling edge, correct data then transmitted.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target: FSM states, ACK/NACK levels, default address.
package i2c_slave_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
   } state_t;

   localparam logic       ACK            = 1'b0;
   localparam logic       NACK           = 1'b1;
   localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;
endpackage

// File: rtl/i2c_slave_bus_cond.sv
// SCL/SDA synchronizers plus one-cycle pulses for SCL edges and START/STOP conditions.
module i2c_slave_bus_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_prev, sda_prev;

   // Idle bus is high on both lines, so presetting to 1 avoids a false edge out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl;
         sda_prev <= sda;
      end
   end

   assign scl      = scl_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl & ~scl_prev;
   assign scl_fall = ~scl & scl_prev;
   assign start    = scl & scl_prev & sda_prev & ~sda;
   assign stop     = scl & scl_prev & ~sda_prev & sda;
endmodule

// File: rtl/i2c_slave_opencores.sv
// I2C target at one fixed 7-bit address with a byte-wide, auto-incrementing register strobe port.
// Define I2C_SLAVE_CLK_STRETCH_EN to add reg_rdy_i and hold SCL low after each strobe until it is seen.
module i2c_slave_opencores
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
   parameter int         REG_ADDR_W  = 8,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  scl_pad_in,
   input  logic                  sda_pad_in,
   output logic                  scl_pad_out,
   output logic                  scl_pad_en,
   output logic                  sda_pad_out,
   output logic                  sda_pad_en,
   output logic [REG_ADDR_W-1:0] reg_addr_o,
   output logic [7:0]            reg_wdata_o,
   output logic                  reg_we_o,
   output logic                  reg_rd_o,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
   input  logic                  reg_rdy_i,
`endif
   input  logic [7:0]            reg_rdata_i,
   output logic                  busy_o
);
   state_t     state, nxt;
   logic       scl, sda, scl_rise, scl_fall, start, stop;
   logic [7:0] shreg, tx;
   logic [3:0] cnt;
   logic       rw, sda_drive, hold, cap;
   logic       byte_done, match;

   i2c_slave_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
      .clk(wb_clk_i), .rst(wb_rst_i), .scl_in(scl_pad_in), .sda_in(sda_pad_in),
      .scl(scl), .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start(start), .stop(stop)
   );

   assign byte_done = (cnt == 4'd8);
   assign match     = (shreg[7:1] == SLAVE_ADDR);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
   localparam bit STRETCH = 1'b1;
   logic pend, pend_rd;

   // SCL is grabbed on the first falling edge after a strobe and let go once user logic is ready.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || stop) begin
         pend    <= 1'b0;
         pend_rd <= 1'b0;
         hold    <= 1'b0;
      end else if (reg_we_o || reg_rd_o) begin
         pend    <= 1'b1;
         pend_rd <= reg_rd_o;
      end else if (pend && !hold && scl_fall) begin
         hold <= 1'b1;
      end else if (hold && reg_rdy_i) begin
         hold    <= 1'b0;
         pend    <= 1'b0;
         pend_rd <= 1'b0;
      end
   end
   assign cap = hold & reg_rdy_i & pend_rd;
`else
   localparam bit STRETCH = 1'b0;
   logic rd_d;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) rd_d <= 1'b0;
      else          rd_d <= reg_rd_o;
   end
   assign hold = 1'b0;
   assign cap  = rd_d;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (stop) nxt = IDLE;
      else if (start) nxt = ADDR;
      else begin
         case (state)
            ADDR:      if (scl_fall && byte_done) nxt = match ? ADDR_ACK : IDLE;
            ADDR_ACK:  if (scl_fall) nxt = rw ? RDATA : PTR;
            PTR:       if (scl_fall && byte_done) nxt = PTR_ACK;
            PTR_ACK:   if (scl_fall) nxt = WDATA;
            WDATA:     if (scl_fall && byte_done) nxt = WDATA_ACK;
            WDATA_ACK: if (scl_fall) nxt = WDATA;
            RDATA:     if (scl_fall && byte_done) nxt = RDATA_ACK;
            RDATA_ACK: begin
               if (scl_rise && sda == NACK) nxt = IDLE;
               else if (scl_fall)           nxt = RDATA;
            end
            default: ;
         endcase
      end
   end

   // Release on STOP is combinational so SDA lets go in the detection cycle itself.
   always_comb begin
      sda_pad_out = 1'b0;
      scl_pad_out = 1'b0;
      sda_pad_en  = ~(sda_drive & ~stop);
      scl_pad_en  = ~hold;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         shreg       <= '0;
         tx          <= '0;
         cnt         <= '0;
         rw          <= 1'b0;
         sda_drive   <= 1'b0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         reg_we_o    <= 1'b0;
         reg_rd_o    <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         reg_we_o <= 1'b0;
         reg_rd_o <= 1'b0;
         if (reg_we_o) reg_addr_o <= reg_addr_o + REG_ADDR_W'(1);
         if (stop || start) begin
            sda_drive <= 1'b0;
            cnt       <= '0;
            if (stop) busy_o <= 1'b0;
         end else begin
            if (scl_rise && (state == ADDR || state == PTR || state == WDATA)) begin
               shreg <= {shreg[6:0], sda};
               cnt   <= cnt + 4'd1;
            end
            if (scl_fall) begin
               case (state)
                  ADDR: if (byte_done) begin
                     sda_drive <= match;
                     busy_o    <= match;
                     rw        <= shreg[0];
                     reg_rd_o  <= match & shreg[0];
                  end
                  PTR: if (byte_done) begin
                     reg_addr_o <= REG_ADDR_W'(shreg);
                     sda_drive  <= 1'b1;
                  end
                  WDATA: if (byte_done) begin
                     reg_wdata_o <= shreg;
                     reg_we_o    <= 1'b1;
                     sda_drive   <= 1'b1;
                  end
                  ADDR_ACK, PTR_ACK, WDATA_ACK, RDATA_ACK: begin
                     if (state == RDATA_ACK || (state == ADDR_ACK && rw)) begin
                        sda_drive <= ~tx[7];
                        tx        <= {tx[6:0], 1'b0};
                        cnt       <= 4'd1;
                     end else begin
                        sda_drive <= 1'b0;
                        cnt       <= '0;
                     end
                  end
                  RDATA: begin
                     if (byte_done) sda_drive <= 1'b0;
                     else begin
                        sda_drive <= ~tx[7];
                        tx        <= {tx[6:0], 1'b0};
                        cnt       <= cnt + 4'd1;
                     end
                  end
                  default: ;
               endcase
            end
            if (state == RDATA_ACK && scl_rise) begin
               if (sda == ACK) begin
                  reg_addr_o <= reg_addr_o + REG_ADDR_W'(1);
                  reg_rd_o   <= 1'b1;
               end else begin
                  busy_o <= 1'b0;
               end
            end
         end
         // With stretching, fresh read data arrives after the MSB slot opened; replace it while SCL is held.
         if (cap) begin
            if (STRETCH && state == RDATA) begin
               sda_drive <= ~reg_rdata_i[7];
               tx        <= {reg_rdata_i[6:0], 1'b0};
            end else begin
               tx <= reg_rdata_i;
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave_opencores.sv
// Bench for i2c_slave_opencores: bit-level I2C master, transaction-level expectation queues, per-cycle strobe checker.
module tb_i2c_slave_opencores;
   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       scl_pad_out, scl_pad_en, sda_pad_out, sda_pad_en;
   logic       reg_we_o, reg_rd_o, busy_o;
   logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;

   int          total = 0;
   int          bad   = 0;
   bit          quiet = 1'b0;
   logic [7:0]  model_ptr;
   logic [15:0] wq[$];
   logic [15:0] wlog[$];
   logic [7:0]  rq[$];

   always #5 clk = ~clk;

   // Open-drain wiring: a pad enable of 0 pulls its line low.
   wire scl_line = scl_m & (scl_pad_en | scl_pad_out);
   wire sda_line = sda_m & (sda_pad_en | sda_pad_out);

   // Register file behaviour requested for reads: each location holds its address plus one.
   assign reg_rdata_i = reg_addr_o + 8'd1;

   i2c_slave_opencores dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .scl_pad_in(scl_line), .sda_pad_in(sda_line),
      .scl_pad_out(scl_pad_out), .scl_pad_en(scl_pad_en),
      .sda_pad_out(sda_pad_out), .sda_pad_en(sda_pad_en),
      .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_we_o(reg_we_o), .reg_rd_o(reg_rd_o),
      .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("pad_out_const", {30'd0, scl_pad_out, sda_pad_out}, 32'd0);
         check("scl_released", {31'd0, scl_pad_en}, 32'd1);
         check("we_rd_exclusive", {31'd0, reg_we_o & reg_rd_o}, 32'd0);
         if (reg_we_o) begin
            check("we_expected", {31'd0, wq.size() > 0}, 32'd1);
            if (wq.size() > 0) check("we_addr_data", {16'd0, reg_addr_o, reg_wdata_o}, {16'd0, wq.pop_front()});
            wlog.push_back({reg_addr_o, reg_wdata_o});
         end
         if (reg_rd_o) begin
            check("rd_expected", {31'd0, rq.size() > 0}, 32'd1);
            if (rq.size() > 0) check("rd_addr", {24'd0, reg_addr_o}, {24'd0, rq.pop_front()});
         end
         if (quiet) begin
            check("quiet_sda_en", {31'd0, sda_pad_en}, 32'd1);
            check("quiet_busy", {31'd0, busy_o}, 32'd0);
         end
      end
   end

   task automatic q();
      repeat (10) @(posedge clk);
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      sda_m = 1'b0; q();
      scl_m = 1'b0; q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; q();
      scl_m = 1'b1; q();
      sda_m = 1'b1; q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      settle();
      b = sda_line;
      q();
      scl_m = 1'b0; q();
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic a;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      get_bit(a);
      check(nm, {31'd0, a}, {31'd0, ~exp_ack});
   endtask

   task automatic rd_byte(output logic [7:0] d);
      logic [7:0] t;
      logic       b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         t[i] = b;
      end
      d = t;
   endtask

   initial begin
      logic [7:0] d, e;
      logic [7:0] wdat [2];
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; model_ptr = 8'h00;
      repeat (5) @(posedge clk);
      settle();
      check("rst_sda_en", {31'd0, sda_pad_en}, 32'd1);
      check("rst_scl_en", {31'd0, scl_pad_en}, 32'd1);
      check("rst_pad_out", {30'd0, scl_pad_out, sda_pad_out}, 32'd0);
      check("rst_addr", {24'd0, reg_addr_o}, 32'd0);
      check("rst_wdata", {24'd0, reg_wdata_o}, 32'd0);
      check("rst_strobes", {30'd0, reg_we_o, reg_rd_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      rst = 1'b0;
      q();

      // Write 0x11, 0x22 starting at 0x10.
      bus_start();
      wr_byte(8'hA0, 1'b1, "t1_addr_ack");
      wr_byte(8'h10, 1'b1, "t1_ptr_ack");
      model_ptr = 8'h10;
      settle();
      check("t1_busy_mid", {31'd0, busy_o}, 32'd1);
      wdat[0] = 8'h11; wdat[1] = 8'h22;
      for (int i = 0; i < 2; i++) begin
         wq.push_back({model_ptr, wdat[i]});
         model_ptr = model_ptr + 8'd1;
         wr_byte(wdat[i], 1'b1, "t1_data_ack");
      end
      bus_stop();
      settle();
      check("t1_busy_after_stop", {31'd0, busy_o}, 32'd0);
      check("t1_ptr", {24'd0, reg_addr_o}, {24'd0, model_ptr});
      check("t1_ptr_lit", {24'd0, reg_addr_o}, 32'h12);
      check("t1_w0_lit", {16'd0, wlog[0]}, 32'h1011);
      check("t1_w1_lit", {16'd0, wlog[1]}, 32'h1122);

      // Set pointer 0x20, repeated START, read two bytes (ACK then NACK).
      bus_start();
      wr_byte(8'hA0, 1'b1, "t2_addr_w_ack");
      wr_byte(8'h20, 1'b1, "t2_ptr_ack");
      model_ptr = 8'h20;
      bus_start();
      rq.push_back(model_ptr);
      wr_byte(8'hA1, 1'b1, "t2_addr_r_ack");
      rd_byte(d);
      e = model_ptr + 8'd1;
      check("t2_byte0", {24'd0, d}, {24'd0, e});
      check("t2_byte0_lit", {24'd0, d}, 32'h21);
      model_ptr = model_ptr + 8'd1;
      rq.push_back(model_ptr);
      send_bit(1'b0);
      rd_byte(d);
      e = model_ptr + 8'd1;
      check("t2_byte1", {24'd0, d}, {24'd0, e});
      check("t2_byte1_lit", {24'd0, d}, 32'h22);
      send_bit(1'b1);
      settle();
      check("t2_busy_after_nack", {31'd0, busy_o}, 32'd0);
      check("t2_sda_released", {31'd0, sda_pad_en}, 32'd1);
      bus_stop();
      check("t2_ptr_lit", {24'd0, reg_addr_o}, 32'h21);

      // Foreign address 0x51: bus must be left alone entirely.
      q();
      quiet = 1'b1;
      bus_start();
      wr_byte(8'hA2, 1'b0, "t3_addr_nack");
      wr_byte(8'h55, 1'b0, "t3_data_nack");
      bus_stop();
      q();
      quiet = 1'b0;
      check("t3_ptr_kept", {24'd0, reg_addr_o}, {24'd0, model_ptr});

      // Pointer wrap: writes at 0xFF then 0x00.
      bus_start();
      wr_byte(8'hA0, 1'b1, "t4_addr_ack");
      wr_byte(8'hFF, 1'b1, "t4_ptr_ack");
      model_ptr = 8'hFF;
      wdat[0] = 8'h77; wdat[1] = 8'h88;
      for (int i = 0; i < 2; i++) begin
         wq.push_back({model_ptr, wdat[i]});
         model_ptr = model_ptr + 8'd1;
         wr_byte(wdat[i], 1'b1, "t4_data_ack");
      end
      bus_stop();
      settle();
      check("t4_ptr", {24'd0, reg_addr_o}, {24'd0, model_ptr});
      check("t4_ptr_lit", {24'd0, reg_addr_o}, 32'h01);
      check("t4_wrap_lit", {16'd0, wlog[wlog.size()-1]}, 32'h0088);

      // STOP after four data bits discards the byte; the next transfer still works.
      bus_start();
      wr_byte(8'hA0, 1'b1, "t5_addr_ack");
      wr_byte(8'h30, 1'b1, "t5_ptr_ack");
      model_ptr = 8'h30;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_stop();
      settle();
      check("t5_sda_released", {31'd0, sda_pad_en}, 32'd1);
      check("t5_busy", {31'd0, busy_o}, 32'd0);
      check("t5_ptr", {24'd0, reg_addr_o}, {24'd0, model_ptr});
      bus_start();
      wr_byte(8'hA0, 1'b1, "t5b_addr_ack");
      wr_byte(8'h40, 1'b1, "t5b_ptr_ack");
      model_ptr = 8'h40;
      wq.push_back({model_ptr, 8'h5A});
      model_ptr = model_ptr + 8'd1;
      wr_byte(8'h5A, 1'b1, "t5b_data_ack");
      bus_stop();

      // Reset while the address ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5);
      sda_m = 1'b1; q();
      scl_m = 1'b1; q();
      settle();
      check("t6_ack_driven", {31'd0, sda_pad_en}, 32'd0);
      check("t6_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      settle();
      check("t6_rst_sda_en", {31'd0, sda_pad_en}, 32'd1);
      check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
      check("t6_rst_addr", {24'd0, reg_addr_o}, 32'd0);
      rst = 1'b0;
      model_ptr = 8'h00;
      q();
      scl_m = 1'b0; q();
      bus_stop();
      q();

      check("wq_drained", wq.size(), 32'd0);
      check("rq_drained", rq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
